// File: rtl/handshake_arbiter.sv
// Round-robin arbiter sharing one Handshaker transmit channel among NUM_REQ requesters.
// Grants one requester, captures its word, pulses HS_Start, then holds the channel
// until HS_Done returns.
// Optional feature: define HS_ARB_TIMEOUT_EN to abandon a transfer after TIMEOUT WAIT cycles
// and raise the sticky Timeout flag.
module handshake_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WID_DATA = 32,
  parameter int unsigned TIMEOUT  = 1023,
  localparam int unsigned WID_OWN = $clog2(NUM_REQ)
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*WID_DATA-1:0]  Data,
  output logic [NUM_REQ-1:0]           Grant,
  output logic                         HS_Start,
  output logic [WID_DATA-1:0]          HS_Data,
  input  logic                         HS_Done,
  output logic                         Busy,
  output logic [WID_OWN-1:0]           Owner,
  output logic                         Timeout
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [WID_OWN-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                start_q, start_d;
  logic [WID_DATA-1:0] data_q, data_d;
  logic [WID_OWN-1:0]  owner_q, owner_d;
  logic [WID_OWN-1:0]  sel;
  logic                found;
  logic                done_ok;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int unsigned WID_CNT = $clog2(TIMEOUT + 1);
  logic [WID_CNT-1:0] cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
`endif

  // A Done that coincides with our own start pulse belongs to an earlier transfer.
  assign done_ok = HS_Done && !start_q;

  // Pick the first asserted request at or after the pointer, wrapping upward.
  always_comb begin
    int unsigned idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && Req[idx]) begin
        found = 1'b1;
        sel   = WID_OWN'(idx);
      end
    end
  end

  // Next-state logic for the IDLE/WAIT controller and its registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    start_d = 1'b0;
    data_d  = data_q;
    owner_d = owner_q;
`ifdef HS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d      = ST_WAIT;
          grant_d[sel] = 1'b1;
          start_d      = 1'b1;
          data_d       = Data[32'(sel)*WID_DATA +: WID_DATA];
          owner_d      = sel;
          ptr_d        = (32'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
`ifdef HS_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (done_ok) begin
          state_d = ST_IDLE;
`ifdef HS_ARB_TIMEOUT_EN
        end else if (cnt_q == WID_CNT'(TIMEOUT - 1)) begin
          // Limit reached with no Done: give up on this transfer.
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by Reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      start_q <= start_d;
      data_q  <= data_d;
      owner_q <= owner_d;
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  // WAIT-cycle counter and sticky timeout flag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

  assign Grant    = grant_q;
  assign HS_Start = start_q;
  assign HS_Data  = data_q;
  assign Busy     = (state_q == ST_WAIT);
  assign Owner    = owner_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed self-checking bench for handshake_arbiter (NUM_REQ=4, WID_DATA=32, TIMEOUT=8).
// The timeout scenario is selected by HS_ARB_TIMEOUT_EN, matching the RTL build.
module tb_handshake_arbiter;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned WID_DATA = 32;

  logic                        Clock;
  logic                        Reset;
  logic [NUM_REQ-1:0]          Req;
  logic [NUM_REQ*WID_DATA-1:0] Data;
  logic [NUM_REQ-1:0]          Grant;
  logic                        HS_Start;
  logic [WID_DATA-1:0]         HS_Data;
  logic                        HS_Done;
  logic                        Busy;
  logic [1:0]                  Owner;
  logic                        Timeout;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int cyc     = 0;

  handshake_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .WID_DATA (WID_DATA),
    .TIMEOUT  (8)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Req      (Req),
    .Data     (Data),
    .Grant    (Grant),
    .HS_Start (HS_Start),
    .HS_Data  (HS_Data),
    .HS_Done  (HS_Done),
    .Busy     (Busy),
    .Owner    (Owner),
    .Timeout  (Timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 64'(Grant), 64'h0);
    check({tag, "_start"}, 64'(HS_Start), 64'h0);
    check({tag, "_data"}, 64'(HS_Data), 64'h0);
    check({tag, "_busy"}, 64'(Busy), 64'h0);
    check({tag, "_owner"}, 64'(Owner), 64'h0);
    check({tag, "_timeout"}, 64'(Timeout), 64'h0);
  endtask

  // Pulse Done for one cycle, then check the channel is released.
  task automatic done_pulse(input string tag);
    HS_Done = 1'b1;
    tick();
    HS_Done = 1'b0;
    check({tag, "_busy_after_done"}, 64'(Busy), 64'h0);
  endtask

  initial begin
    logic [31:0] words [NUM_REQ];
    int          order [5];
    int          last_cyc;
    int          lim;

    words[0] = 32'h0000_0011;
    words[1] = 32'hA5A5_0022;
    words[2] = 32'h5A5A_0033;
    words[3] = 32'hDEAD_0044;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    last_cyc = 0;

    Reset   = 1'b0;
    Req     = '0;
    HS_Done = 1'b0;
    Data    = {words[3], words[2], words[1], words[0]};

    // Reset state
    tick();
    check_idle_outputs("reset");
    tick();
    Reset = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // Single request from requester 0
    Req = 4'b0001;
    tick();
    check("t1_grant", 64'(Grant), 64'h1);
    check("t1_start", 64'(HS_Start), 64'h1);
    check("t1_data", 64'(HS_Data), 64'h11);
    check("t1_owner", 64'(Owner), 64'h0);
    check("t1_busy", 64'(Busy), 64'h1);
    Req = 4'b0000;
    tick();
    check("t1_grant_drop", 64'(Grant), 64'h0);
    check("t1_start_drop", 64'(HS_Start), 64'h0);
    check("t1_data_hold", 64'(HS_Data), 64'h11);
    done_pulse("t1");

    // Done in the start cycle is discarded; Done in IDLE is ignored (pointer now 1)
    Req = 4'b0010;
    tick();
    check("t4_grant", 64'(Grant), 64'h2);
    HS_Done = 1'b1;
    Req = 4'b0000;
    tick();
    HS_Done = 1'b0;
    check("t4_busy_after_early_done", 64'(Busy), 64'h1);
    tick();
    check("t4_busy_still", 64'(Busy), 64'h1);
    done_pulse("t4");
    HS_Done = 1'b1;
    tick();
    HS_Done = 1'b0;
    check("t4_idle_done_busy", 64'(Busy), 64'h0);
    check("t4_idle_done_grant", 64'(Grant), 64'h0);
    check("t4_idle_done_start", 64'(HS_Start), 64'h0);

    // Req1 raised while requester 0 holds the channel (pointer now 2, scan wraps to 0)
    Req = 4'b0001;
    tick();
    check("t3_grant0", 64'(Grant), 64'h1);
    Req = 4'b0010;
    tick();
    check("t3_no_grant_wait1", 64'(Grant), 64'h0);
    tick();
    check("t3_no_grant_wait2", 64'(Grant), 64'h0);
    HS_Done = 1'b1;
    tick();
    HS_Done = 1'b0;
    check("t3_no_grant_done_plus1", 64'(Grant), 64'h0);
    check("t3_busy_done_plus1", 64'(Busy), 64'h0);
    tick();
    check("t3_grant1_done_plus2", 64'(Grant), 64'h2);
    check("t3_owner1", 64'(Owner), 64'h1);
    check("t3_data1", 64'(HS_Data), 64'(words[1]));
    Req = 4'b0000;
    tick();
    done_pulse("t3");

    // Reset mid-WAIT clears outputs at once; pointer restarts at 0 (pointer now 2)
    Req = 4'b0100;
    tick();
    check("t6_grant2", 64'(Grant), 64'h4);
    Req = 4'b0000;
    tick();
    check("t6_busy_before", 64'(Busy), 64'h1);
    Reset = 1'b0;
    #1;
    check_idle_outputs("t6_async");
    tick();
    Reset = 1'b1;
    Req = 4'b1000;
    tick();
    check("t6_grant3", 64'(Grant), 64'h8);
    check("t6_owner3", 64'(Owner), 64'h3);
    check("t6_data3", 64'(HS_Data), 64'(words[3]));
    Req = 4'b0000;
    tick();
    done_pulse("t6");

    // All requesters held; Done three cycles after each start (pointer now 0)
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      lim = 0;
      while (!HS_Start && lim < 20) begin
        tick();
        lim++;
      end
      check($sformatf("t2_start_seen%0d", k), 64'(HS_Start), 64'h1);
      check($sformatf("t2_grant%0d", k), 64'(Grant), 64'(4'b0001 << order[k]));
      check($sformatf("t2_data%0d", k), 64'(HS_Data), 64'(words[order[k]]));
      if (k > 0) check($sformatf("t2_gap%0d", k), 64'(cyc - last_cyc), 64'd5);
      last_cyc = cyc;
      if (k == 4) Req = 4'b0000;
      tick();
      tick();
      tick();
      HS_Done = 1'b1;
      tick();
      HS_Done = 1'b0;
    end
    check("t2_busy_end", 64'(Busy), 64'h0);

`ifdef HS_ARB_TIMEOUT_EN
    // No Done: WAIT lasts 8 cycles, then Timeout sets and sticks (pointer now 1)
    Req = 4'b0001;
    tick();
    check("t5_grant", 64'(Grant), 64'h1);
    Req = 4'b0000;
    for (int i = 0; i < 7; i++) tick();
    check("t5_busy_cycle7", 64'(Busy), 64'h1);
    check("t5_timeout_cycle7", 64'(Timeout), 64'h0);
    tick();
    check("t5_busy_fell", 64'(Busy), 64'h0);
    check("t5_timeout_set", 64'(Timeout), 64'h1);
    for (int i = 0; i < 4; i++) tick();
    check("t5_timeout_sticky", 64'(Timeout), 64'h1);
    // Done on the limit cycle wins
    Reset = 1'b0;
    #1;
    check("t5_timeout_cleared", 64'(Timeout), 64'h0);
    tick();
    Reset = 1'b1;
    Req = 4'b0001;
    tick();
    Req = 4'b0000;
    for (int i = 0; i < 7; i++) tick();
    HS_Done = 1'b1;
    tick();
    HS_Done = 1'b0;
    check("t5_limit_done_busy", 64'(Busy), 64'h0);
    check("t5_limit_done_timeout", 64'(Timeout), 64'h0);
`else
    // No timeout built: WAIT persists until Done (pointer now 1)
    Req = 4'b0001;
    tick();
    check("t5_grant", 64'(Grant), 64'h1);
    Req = 4'b0000;
    for (int i = 0; i < 12; i++) tick();
    check("t5_busy_persist", 64'(Busy), 64'h1);
    check("t5_timeout_tied", 64'(Timeout), 64'h0);
    done_pulse("t5");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
